// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: UART receiver with configurable word length, parity and stop
// bits. Synchronised, majority-voted input; false-start rejection; parity,
// framing and break reporting on a one-cycle new_data strobe.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | line idle, waiting for rx_s low
// ST_START     | timing to mid start bit, rejects short low pulses
// ST_DATA      | sampling DATA_BITS data bits, LSB first
// ST_PARITY    | sampling the parity bit (only when PARITY != 0)
// ST_STOP      | sampling STOP_BITS stop bits, strobe after the last one
// ST_WAIT_HIGH | last stop bit was low; hold off until the line returns high
module uart_rx_cfg #(
  parameter int CLK_PER_BIT = 54,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 new_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CTR_HALF  = CW'(CLK_PER_BIT >> 1);
  localparam logic [CW-1:0] CTR_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CTR_ONE   = CW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic          ODD_MODE  = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [2:0]           hist_q;
  logic [CW-1:0]        ctr_q, ctr_d;
  logic [BW-1:0]        bit_ctr_q, bit_ctr_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_flag_q, par_flag_d;
  logic                 frm_flag_q, frm_flag_d;
  logic                 one_seen_q, one_seen_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 new_data_q, new_data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 maj;
  logic                 par_exp;

  assign maj     = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign par_exp = (^shift_q) ^ ODD_MODE;

  // Two-flop synchroniser and three-deep history for the majority vote
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      hist_q    <= 3'b111;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      hist_q    <= {hist_q[1:0], rx_s_q};
    end
  end

  // Frame state, counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ctr_q      <= '0;
      bit_ctr_q  <= '0;
      shift_q    <= '0;
      par_flag_q <= 1'b0;
      frm_flag_q <= 1'b0;
      one_seen_q <= 1'b0;
      data_q     <= '0;
      new_data_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      bit_ctr_q  <= bit_ctr_d;
      shift_q    <= shift_d;
      par_flag_q <= par_flag_d;
      frm_flag_q <= frm_flag_d;
      one_seen_q <= one_seen_d;
      data_q     <= data_d;
      new_data_q <= new_data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  // Next-state, bit timing, sampling and end-of-frame result capture
  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    bit_ctr_d  = bit_ctr_q;
    shift_d    = shift_q;
    par_flag_d = par_flag_q;
    frm_flag_d = frm_flag_q;
    one_seen_d = one_seen_q;
    data_d     = data_q;
    new_data_d = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    case (state_q)
      ST_IDLE: begin
        ctr_d     = '0;
        bit_ctr_d = '0;
        if (!rx_s_q) begin
          state_d    = ST_START;
          par_flag_d = 1'b0;
          frm_flag_d = 1'b0;
          one_seen_d = 1'b0;
        end
      end
      ST_START: begin
        if (ctr_q == CTR_HALF) begin
          ctr_d   = '0;
          state_d = maj ? ST_IDLE : ST_DATA;
        end else begin
          ctr_d = ctr_q + CTR_ONE;
        end
      end
      ST_DATA: begin
        if (ctr_q == CTR_LAST) begin
          ctr_d      = '0;
          shift_d    = {maj, shift_q[DATA_BITS-1:1]};
          one_seen_d = one_seen_q | maj;
          if (bit_ctr_q == BIT_LAST) begin
            bit_ctr_d = '0;
            state_d   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_ctr_d = bit_ctr_q + BIT_ONE;
          end
        end else begin
          ctr_d = ctr_q + CTR_ONE;
        end
      end
      ST_PARITY: begin
        if (ctr_q == CTR_LAST) begin
          ctr_d      = '0;
          one_seen_d = one_seen_q | maj;
          if (maj != par_exp) par_flag_d = 1'b1;
          state_d    = ST_STOP;
        end else begin
          ctr_d = ctr_q + CTR_ONE;
        end
      end
      ST_STOP: begin
        if (ctr_q == CTR_LAST) begin
          ctr_d      = '0;
          one_seen_d = one_seen_q | maj;
          if (!maj) frm_flag_d = 1'b1;
          if (bit_ctr_q == STOP_LAST) begin
            bit_ctr_d  = '0;
            new_data_d = 1'b1;
            data_d     = shift_q;
            perr_d     = par_flag_q;
            ferr_d     = frm_flag_q | ~maj;
            brk_d      = ~(one_seen_q | maj);
            state_d    = maj ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            bit_ctr_d = bit_ctr_q + BIT_ONE;
          end
        end else begin
          ctr_d = ctr_q + CTR_ONE;
        end
      end
      ST_WAIT_HIGH: begin
        ctr_d     = '0;
        bit_ctr_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data       = data_q;
  assign new_data   = new_data_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign break_det  = brk_q;

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver. It sits between an asynchronous serial input pin and the byte-oriented control logic on the board. It generalises the fixed 8N1 receiver to configurable word length, parity and stop bits. It adds an input synchroniser, majority-vote sampling, false-start rejection, and parity, framing and break error reporting.

## Interface

Parameters:
- CLK_PER_BIT, 54, clock cycles per bit period; must be ≥ 8.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-low.
- rx  in  1  asynchronous serial line; idles high.
- data  out  DATA_BITS  last received word, LSB = first bit on the line.
- new_data  out  1  one-cycle strobe; data and all error flags are valid in this cycle.
- parity_err  out  1  parity mismatch on the last frame; always 0 when PARITY=0.
- frame_err  out  1  at least one stop bit of the last frame sampled low.
- break_det  out  1  last frame was all-zero: data, parity and stop bits all low.

## Operation

**Input path**
- rx passes through a 2-flop synchroniser to give rx_s.
- A 3-bit history register holds the last three rx_s values.
- The sampled bit value (maj) is the majority vote of those three values.

**Counters and state**
- ctr: width $clog2(CLK_PER_BIT).
- bit_ctr: width $clog2(DATA_BITS+1).
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.

**IDLE**
- ctr = 0 and bit_ctr = 0.
- When rx_s == 0, go to START.

**START**
- ctr increments each cycle.
- At ctr == CLK_PER_BIT>>1:
  - If maj == 1, this is a false start: go to IDLE and emit no strobe.
  - Otherwise, clear ctr and go to DATA.

**DATA**
- ctr increments each cycle.
- At ctr == CLK_PER_BIT-1:
  - Shift maj into the MSB of the shift register (right shift, so the first bit received ends up as the LSB).
  - Clear ctr and increment bit_ctr.
- After DATA_BITS samples, go to PARITY if PARITY ≠ 0, otherwise go to STOP.

**PARITY**
- One bit period, sampled at ctr == CLK_PER_BIT-1.
- Expected parity bit:
  - Even mode: the XOR of the data bits.
  - Odd mode: the inverse of that XOR.
- A mismatch latches an internal parity flag.

**STOP**
- STOP_BITS bit periods, each sampled at ctr == CLK_PER_BIT-1.
- Any low sample latches an internal frame flag.
- After the last stop sample:
  - Assert new_data for the next cycle.
  - Update data, parity_err, frame_err and break_det in the same cycle.
  - If the last stop sample was high, go to IDLE. If it was low, go to WAIT_HIGH.

**WAIT_HIGH**
- Stay until rx_s == 1, then go to IDLE.
- No new start bit is detected while in this state.

**Break**
- break_det = 1 when all data bits, the parity bit (if present) and every stop bit sampled 0.
- frame_err is also 1 in that case.

**Outputs**
- data and the error flags hold their values until the next new_data strobe.
- Internal flags are cleared on entry to START.

**Reset (rst == 0 at a clock edge)**
- State = IDLE; ctr and bit_ctr = 0.
- Synchroniser and history flops = 1.
- data = 0; new_data, parity_err, frame_err and break_det = 0.
- Reset has priority over all other activity; asserting it mid-frame discards the frame with no strobe.

## Timing

- Input latency: 2 cycles from the rx pin to rx_s.
- Start edge: first rx_s low in IDLE → enter START on the next edge.
- First data sample: START lasts (CLK_PER_BIT>>1)+1 cycles, then the first data sample comes CLK_PER_BIT cycles later. Each following bit adds CLK_PER_BIT cycles.
- Strobe: new_data is high exactly 1 cycle, in the cycle after the last stop-bit sample. It is never high on two consecutive cycles.
- Back-to-back frames with STOP_BITS=1: a start bit arriving immediately after the stop bit is accepted. The stop sample falls at mid-bit, leaving half a bit of margin before the next start edge.
- Glitch rejection: any rx low pulse shorter than about CLK_PER_BIT/2 cycles is rejected as a false start.
- Majority vote: a single-cycle glitch at a sample point does not change the sampled value.

## Test plan

Bench settings are CLK_PER_BIT=16 unless stated.

1. 8N1, send 0x55 then 0xA3 back-to-back → two new_data pulses with data=0x55 then 0xA3; all error flags 0.
2. DATA_BITS=7, PARITY=2 (even):
   - Send 0x41 with parity bit 0 → parity_err=0.
   - Resend with parity bit 1 → parity_err=1, data=0x41.
3. STOP_BITS=2, send 0x3C with the second stop bit low → new_data with data=0x3C and frame_err=1. The receiver then waits for rx high before accepting the next frame.
4. Break: hold rx low for 20 bit periods, then release → exactly one new_data with data=0, frame_err=1, break_det=1. The next valid frame 0x7E decodes correctly with flags 0.
5. Glitches:
   - rx low for 5 cycles in IDLE → no new_data.
   - A 1-cycle high glitch at a data-bit sample point of 0x00 → data=0x00.
6. Assert rst mid-frame (during bit 4) → all outputs 0 on the next cycle. A following complete frame 0x81 is received correctly.
